valu_issue_sched: RTL

- Issue scheduler in front of the vector-lane ALU.
- Accepts one micro-op per cycle over a valid/ready handshake and classifies it by execution latency: single-cycle integer, SIMD multiplier (incl. multiply-accumulate), or FP FMA.
- Reserves the lane's single result-writeback slot ahead of time and stalls issue when two in-flight ops would write back in the same cycle.
- Emits the ALU stage enable plus tag/flag for the writeback stage.

---
 rtl/valu_issue_sched_pkg.sv | 66 ++++++
 rtl/valu_issue_sched_if.sv | 31 +++
 rtl/valu_issue_sched_wb_resv.sv | 55 +++++
 rtl/valu_issue_sched.sv | 90 +++++++++
 4 files changed

// File: rtl/valu_issue_sched_pkg.sv
// Shared types, widths and micro-op decode for the vector-lane ALU issue scheduler.
package valu_pkg;

  localparam int unsigned MICROOP_BIT = 9;
  localparam int unsigned TAG_W       = 5;
  localparam int unsigned INT_LAT     = 1;
  localparam int unsigned MUL_LAT     = 2;
  localparam int unsigned FMA_LAT     = 4;

  // Latency index covers 0..FMA_LAT; slot index covers 0..FMA_LAT-1.
  localparam int unsigned LAT_W = $clog2(FMA_LAT + 1);
  localparam int unsigned IDX_W = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;

  // Class-select field op[7:6].
  localparam int unsigned CLS_HI = 7;
  localparam int unsigned CLS_LO = 6;
  localparam logic [1:0]  CLS_FMA = 2'b01;
  localparam logic [1:0]  CLS_MUL = 2'b10;

  // Multiplier-class function codes in op[5:0].
  localparam logic [5:0] OP_VMULH   = 6'b100100;
  localparam logic [5:0] OP_VMUL    = 6'b100101;
  localparam logic [5:0] OP_VMULHU  = 6'b100110;
  localparam logic [5:0] OP_VMULHSU = 6'b100111;
  localparam logic [5:0] OP_VMACC   = 6'b101101;
  localparam logic [5:0] OP_VNMSAC  = 6'b101001;

  typedef enum logic [1:0] {
    LAT_INT,
    LAT_MUL,
    LAT_FMA
  } lat_class_e;

  // Per-slot writeback payload.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             masked;
  } wb_info_t;

  // Execution-latency class of a micro-op.
  function automatic lat_class_e classify_op(input logic [MICROOP_BIT-1:0] alu_op);
    lat_class_e cls;
    cls = LAT_INT;
    if (alu_op[CLS_HI:CLS_LO] == CLS_FMA) begin
      cls = LAT_FMA;
    end else if (alu_op[CLS_HI:CLS_LO] == CLS_MUL) begin
      case (alu_op[5:0])
        OP_VMULH, OP_VMUL, OP_VMULHU, OP_VMULHSU, OP_VMACC, OP_VNMSAC: cls = LAT_MUL;
        default: cls = LAT_INT;
      endcase
    end
    return cls;
  endfunction

  // Issue-to-writeback latency of a class.
  function automatic logic [LAT_W-1:0] class_lat(input lat_class_e cls);
    logic [LAT_W-1:0] lat;
    case (cls)
      LAT_MUL: lat = LAT_W'(MUL_LAT);
      LAT_FMA: lat = LAT_W'(FMA_LAT);
      default: lat = LAT_W'(INT_LAT);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/valu_issue_sched_if.sv
// Micro-op intake, ALU enable and writeback bus of the issue scheduler.
interface valu_issue_sched_if
  import valu_pkg::*;
();

  logic                   in_valid;
  logic                   in_ready;
  logic [MICROOP_BIT-1:0] in_alu_op;
  logic [TAG_W-1:0]       in_tag;
  logic                   in_masked;
  logic                   flush;
  logic                   alu_issue;
  logic [MICROOP_BIT-1:0] alu_op_q;
  logic                   wb_valid;
  logic [TAG_W-1:0]       wb_tag;
  logic                   wb_masked;
  logic                   busy;

  // Upstream / pipeline side.
  modport master (
    output in_valid, in_alu_op, in_tag, in_masked, flush,
    input  in_ready, alu_issue, alu_op_q, wb_valid, wb_tag, wb_masked, busy
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_alu_op, in_tag, in_masked, flush,
    output in_ready, alu_issue, alu_op_q, wb_valid, wb_tag, wb_masked, busy
  );

endinterface

// File: rtl/valu_issue_sched_wb_resv.sv
// Writeback-slot reservation shift register with per-slot tag/masked payload.
module valu_wb_resv
  import valu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en_i,
  input  logic [IDX_W-1:0]   set_idx_i,
  input  wb_info_t           set_info_i,
  input  logic               flush_i,
  output logic [FMA_LAT-1:0] slot_o,
  output logic               head_valid_o,
  output wb_info_t           head_info_o
);

  logic [FMA_LAT-1:0] slot_q, slot_d;
  wb_info_t           info_q [FMA_LAT];
  wb_info_t           info_d [FMA_LAT];

  // Shift toward the head every cycle, insert the new reservation, flush clears occupancy.
  always_comb begin
    slot_d = {1'b0, slot_q[FMA_LAT-1:1]};
    for (int unsigned k = 0; k < FMA_LAT - 1; k++) begin
      info_d[k] = info_q[k+1];
    end
    info_d[FMA_LAT-1] = '0;
    if (set_en_i) begin
      slot_d[set_idx_i] = 1'b1;
      info_d[set_idx_i] = set_info_i;
    end
    if (flush_i) begin
      slot_d = '0;
    end
  end

  // Reservation state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      for (int unsigned k = 0; k < FMA_LAT; k++) begin
        info_q[k] <= '0;
      end
    end else begin
      slot_q <= slot_d;
      for (int unsigned k = 0; k < FMA_LAT; k++) begin
        info_q[k] <= info_d[k];
      end
    end
  end

  assign slot_o       = slot_q;
  assign head_valid_o = slot_q[0];
  assign head_info_o  = info_q[0];

endmodule

// File: rtl/valu_issue_sched.sv
// Vector-lane ALU issue scheduler: latency-class decode, writeback-slot reservation and issue stall.
// Optional build macro VALU_IN_ORDER_WB_EN: also stall while any longer-latency op is pending,
// so writeback order follows issue order.
module valu_issue_sched
  import valu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  valu_issue_sched_if.slave   bus
);

  lat_class_e             cls_c;
  logic [LAT_W-1:0]       lat_c;
  logic [IDX_W-1:0]       set_idx_c;
  logic                   block_c;
  logic                   in_ready_c;
  logic                   issue_c;
  logic [FMA_LAT-1:0]     slot_w;
  logic [FMA_LAT:0]       slot_ext_c;
  logic                   head_valid_w;
  wb_info_t               head_info_w;
  wb_info_t               set_info_c;

  logic                   alu_issue_q, alu_issue_d;
  logic [MICROOP_BIT-1:0] alu_op_q, alu_op_d;

  // slot[FMA_LAT] does not exist and always reads as free.
  assign slot_ext_c = {1'b0, slot_w};

  // Decode class, find the target slot and decide whether the op may issue now.
  always_comb begin
    cls_c     = classify_op(bus.in_alu_op);
    lat_c     = class_lat(cls_c);
    set_idx_c = IDX_W'(lat_c - LAT_W'(1));
`ifdef VALU_IN_ORDER_WB_EN
    block_c = 1'b0;
    for (int unsigned k = 0; k <= FMA_LAT; k++) begin
      if (LAT_W'(k) >= lat_c) begin
        block_c = block_c | slot_ext_c[k];
      end
    end
`else
    block_c = slot_ext_c[lat_c];
`endif
    in_ready_c = ~block_c & ~bus.flush;
    issue_c    = bus.in_valid & in_ready_c;
    set_info_c = '{tag: bus.in_tag, masked: bus.in_masked};
  end

  valu_wb_resv u_resv (
    .clk          (clk),
    .rst          (rst),
    .set_en_i     (issue_c),
    .set_idx_i    (set_idx_c),
    .set_info_i   (set_info_c),
    .flush_i      (bus.flush),
    .slot_o       (slot_w),
    .head_valid_o (head_valid_w),
    .head_info_o  (head_info_w)
  );

  // ALU stage enable and operand code; flush never issues since in_ready is low.
  always_comb begin
    alu_issue_d = issue_c;
    alu_op_d    = alu_op_q;
    if (issue_c) begin
      alu_op_d = bus.in_alu_op;
    end
  end

  // ALU stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_issue_q <= 1'b0;
      alu_op_q    <= '0;
    end else begin
      alu_issue_q <= alu_issue_d;
      alu_op_q    <= alu_op_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.alu_issue = alu_issue_q;
  assign bus.alu_op_q  = alu_op_q;
  assign bus.wb_valid  = head_valid_w;
  assign bus.wb_tag    = head_info_w.tag;
  assign bus.wb_masked = head_info_w.masked;
  assign bus.busy      = |slot_w;

endmodule
